spad_input_router: RTL and testbench

Scratchpad-to-PE-array unpacking router and the read-side counterpart of the output router. On a start request it fetches up to GROUP_CNT consecutive packed scratchpad words and unpacks the MEMBER_CNT lane bytes in each word into per-PE lane registers. It then presents all ROUTER_COUNT lanes in parallel to the systolic array and holds them until the array accepts them. The packing order matches the output router's, so any scratchpad region written by the output router reads back lane-for-lane.

---
 rtl/spad_input_router_pkg.sv | 16 +
 rtl/spad_input_router.sv | 118 +++++++++++
 tb/tb_spad_input_router.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/spad_input_router_pkg.sv
// spad_input_router_pkg: router state encoding and the lane packing helpers.
// The output router uses the same helpers, so both routers order lanes the same way.
package spad_input_router_pkg;

    typedef enum logic [1:0] {IDLE, READ, WAIT, HOLD} state_t;

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

    // Lane m of a word starts at this bit; the first lane sits in the MSBs.
    function automatic int lane_lsb(input int m, input int member_cnt, input int dw);
        return (member_cnt - 1 - m) * dw;
    endfunction

endpackage

// File: rtl/spad_input_router.sv
// spad_input_router: fetches packed scratchpad words, unpacks them into per-lane registers
// and holds them for the PE array until it accepts them.
module spad_input_router
    import spad_input_router_pkg::*;
#(
    parameter int SPAD_ADDR_WIDTH = 8,
    parameter int SPAD_DATA_WIDTH = 16,
    parameter int ROUTER_COUNT    = 4,
    parameter int DATA_WIDTH      = 8,
    parameter int MEMBER_CNT      = ceil_div(SPAD_DATA_WIDTH, DATA_WIDTH),
    parameter int GROUP_CNT       = ceil_div(ROUTER_COUNT, MEMBER_CNT),
    parameter int CNT_W           = $clog2(ROUTER_COUNT + 1)
)(
    input  logic                                     i_clk,
    input  logic                                     i_nrst,
    input  logic                                     i_en,
    input  logic [SPAD_ADDR_WIDTH-1:0]               i_start_addr,
    input  logic [CNT_W-1:0]                         i_lane_cnt,
    output logic                                     o_spad_re,
    output logic [SPAD_ADDR_WIDTH-1:0]               o_spad_addr,
    input  logic [SPAD_DATA_WIDTH-1:0]               i_spad_data,
    output logic [0:ROUTER_COUNT-1][DATA_WIDTH-1:0]  o_data,
    output logic [ROUTER_COUNT-1:0]                  o_valid,
    input  logic                                     i_ready,
    output logic                                     o_done
);

    localparam int IDX_W = GROUP_CNT > 1 ? $clog2(GROUP_CNT) : 1;

    state_t                     state;
    logic [SPAD_ADDR_WIDTH-1:0] base;
    logic [CNT_W-1:0]           n;
    logic [IDX_W-1:0]           idx;
    logic [IDX_W-1:0]           last;
    logic                       pend;
    logic [IDX_W-1:0]           pend_idx;
    logic [DATA_WIDTH-1:0]      lanes [ROUTER_COUNT];
    logic [CNT_W-1:0]           n_c;
    logic [ROUTER_COUNT-1:0]    lane_mask;
    logic                       start;

    assign n_c         = i_lane_cnt > CNT_W'(ROUTER_COUNT) ? CNT_W'(ROUTER_COUNT) : i_lane_cnt;
    assign start       = state == IDLE && i_en && n_c != '0;
    assign o_spad_re   = state == READ;
    assign o_spad_addr = state == READ ? base + SPAD_ADDR_WIDTH'(idx) : '0;

    always_comb begin
        o_data    = '0;
        lane_mask = '0;
        for (int i = 0; i < ROUTER_COUNT; i++) begin
            o_data[i]    = state == HOLD ? lanes[i] : '0;
            lane_mask[i] = CNT_W'(i) < n;
        end
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state    <= IDLE;
            base     <= '0;
            n        <= '0;
            idx      <= '0;
            last     <= '0;
            pend     <= 1'b0;
            pend_idx <= '0;
            o_valid  <= '0;
            o_done   <= 1'b0;
        end else begin
            o_done   <= 1'b0;
            pend     <= state == READ;
            pend_idx <= idx;
            case (state)
                IDLE: begin
                    o_done <= i_en && n_c == '0;
                    if (start) begin
                        base  <= i_start_addr;
                        n     <= n_c;
                        idx   <= '0;
                        last  <= IDX_W'(ceil_div(int'(n_c), MEMBER_CNT) - 1);
                        state <= READ;
                    end
                end
                READ: begin
                    idx   <= idx + 1'b1;
                    state <= idx == last ? WAIT : READ;
                end
                WAIT: begin
                    o_valid <= lane_mask;
                    state   <= HOLD;
                end
                HOLD: if (i_ready) begin
                    o_valid <= '0;
                    o_done  <= 1'b1;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Word g, member m lands in lane g*MEMBER_CNT+m; lanes at or beyond N stay cleared.
    for (genvar g = 0; g < GROUP_CNT; g++) begin : g_grp
        for (genvar m = 0; m < MEMBER_CNT; m++) begin : g_mem
            localparam int LANE = g * MEMBER_CNT + m;
            localparam int LSB  = lane_lsb(m, MEMBER_CNT, DATA_WIDTH);
            if (LANE < ROUTER_COUNT) begin : g_lane
                always_ff @(posedge i_clk or negedge i_nrst) begin
                    if (!i_nrst)
                        lanes[LANE] <= '0;
                    else if (start)
                        lanes[LANE] <= '0;
                    else if (pend && pend_idx == IDX_W'(g) && CNT_W'(LANE) < n)
                        lanes[LANE] <= i_spad_data[LSB +: DATA_WIDTH];
                end
            end
        end
    end

endmodule

// File: tb/tb_spad_input_router.sv
// tb_spad_input_router: table-driven loads against a scratchpad model, with a scoreboard
// of expected lane images plus hand-written empty-start and mid-load reset sequences.
module tb_spad_input_router;

    logic              clk = 1'b0;
    logic              nrst;
    logic              en;
    logic [7:0]        start_addr;
    logic [2:0]        lane_cnt;
    logic              spad_re;
    logic [7:0]        spad_addr;
    logic [15:0]       spad_data;
    logic [0:3][7:0]   data;
    logic [3:0]        valid;
    logic              ready;
    logic              done;
    logic [15:0]       mem [256];

    typedef struct {
        logic [7:0]  base;
        logic [2:0]  n;
        logic [31:0] data;
        logic [3:0]  valid;
        int          reads;
        int          hold;
        bit          noise;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  valid;
    } exp_t;

    exp_t sb[$];
    vec_t vecs [5];
    vec_t rv;
    int   checks = 0;
    int   passes = 0;

    always #5 clk = ~clk;

    spad_input_router dut (
        .i_clk        (clk),
        .i_nrst       (nrst),
        .i_en         (en),
        .i_start_addr (start_addr),
        .i_lane_cnt   (lane_cnt),
        .o_spad_re    (spad_re),
        .o_spad_addr  (spad_addr),
        .i_spad_data  (spad_data),
        .o_data       (data),
        .o_valid      (valid),
        .i_ready      (ready),
        .o_done       (done)
    );

    always @(posedge clk) if (spad_re) spad_data <= mem[spad_addr];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Entered and left on a falling edge; cycle 0 is the cycle i_en is high.
    task automatic run_load(input vec_t v);
        int          cyc;
        int          reads;
        bit          nz;
        logic [7:0]  ea;
        logic [31:0] hd;
        logic [3:0]  hv;
        exp_t        e;
        e.data  = v.data;
        e.valid = v.valid;
        sb.push_back(e);
        en = 1'b1; start_addr = v.base; lane_cnt = v.n;
        @(negedge clk);
        en = v.noise; start_addr = 8'h80; lane_cnt = 3'd1;
        cyc = 1; reads = 0; nz = 0;
        while (valid == 4'b0 && cyc < 20) begin
            if (spad_re) begin
                ea = v.base + 8'(reads);
                chk("rd_addr", spad_addr, ea);
                reads++;
            end
            if (data != '0) nz = 1;
            @(negedge clk);
            cyc++;
        end
        chk("latency", cyc, v.reads + 2);
        chk("reads", reads, v.reads);
        chk("pre_data_zero", nz, 0);
        if (sb.size() == 0) chk("sb_empty", 1, 0);
        else begin
            e = sb.pop_front();
            chk("data", data, e.data);
            chk("valid", valid, e.valid);
        end
        hd = data; hv = valid;
        for (int h = 0; h < v.hold; h++) begin
            @(negedge clk);
            chk("hold_data", data, hd);
            chk("hold_valid", valid, hv);
            chk("hold_re", spad_re, 0);
        end
        ready = 1'b1; en = 1'b0;
        @(negedge clk);
        ready = 1'b0;
        chk("done", done, 1);
        chk("valid_clr", valid, 0);
        chk("data_idle", data, 0);
        @(negedge clk);
        chk("done_pulse", done, 0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'hEEEE;
        mem[8'h10] = 16'hA1B2;
        mem[8'h11] = 16'hC3D4;
        mem[8'hFF] = 16'h5566;
        mem[8'h00] = 16'h7788;
        mem[8'h20] = 16'h1122;
        spad_data = '0;
        vecs[0] = '{8'h10, 3'd4, 32'hA1B2C3D4, 4'b1111, 2, 5, 1'b0};
        vecs[1] = '{8'h10, 3'd3, 32'hA1B2C300, 4'b0111, 2, 2, 1'b1};
        vecs[2] = '{8'h10, 3'd1, 32'hA1000000, 4'b0001, 1, 0, 1'b0};
        vecs[3] = '{8'hFF, 3'd7, 32'h55667788, 4'b1111, 2, 1, 1'b1};
        vecs[4] = '{8'h20, 3'd2, 32'h11220000, 4'b0011, 1, 0, 1'b0};
        nrst = 1'b0; en = 1'b0; ready = 1'b0; start_addr = '0; lane_cnt = '0;
        repeat (3) @(negedge clk);
        chk("rst_re", spad_re, 0);
        chk("rst_addr", spad_addr, 0);
        chk("rst_data", data, 0);
        chk("rst_valid", valid, 0);
        chk("rst_done", done, 0);
        nrst = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 5; i++) run_load(vecs[i]);
        en = 1'b1; start_addr = 8'h30; lane_cnt = 3'd0;
        @(negedge clk);
        en = 1'b0;
        chk("empty_done", done, 1);
        chk("empty_re", spad_re, 0);
        @(negedge clk);
        chk("empty_done_pulse", done, 0);
        chk("empty_re2", spad_re, 0);
        chk("empty_valid", valid, 0);
        en = 1'b1; start_addr = 8'h10; lane_cnt = 3'd4;
        @(negedge clk);
        en = 1'b0;
        chk("mid_re1", spad_re, 1);
        @(negedge clk);
        chk("mid_addr2", spad_addr, 8'h11);
        #2 nrst = 1'b0;
        #1;
        chk("mid_rst_re", spad_re, 0);
        chk("mid_rst_addr", spad_addr, 0);
        chk("mid_rst_data", data, 0);
        chk("mid_rst_valid", valid, 0);
        chk("mid_rst_done", done, 0);
        repeat (2) @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);
        chk("post_rst_re", spad_re, 0);
        chk("post_rst_valid", valid, 0);
        rv = '{8'h20, 3'd2, 32'h11220000, 4'b0011, 1, 0, 1'b0};
        run_load(rv);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
